// File: rtl/reg_file_pkg.sv
// Shared widths and the writeback payload type used by the writeback path.
package reg_file_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned REG_DATA_W    = 32;
    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned WB_FIFO_DEPTH = 2;
    localparam int unsigned STARVE_LIMIT  = 3;
    localparam int unsigned STARVE_W      = 2;
    localparam int unsigned WB_CNT_W      = $clog2(WB_FIFO_DEPTH + 1);

    // One buffered register-file write
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_file_writeback_if.sv
// Writeback bus: ALU and load-unit request channels, stall input, the
// register-file write port, and the pending/occupancy status.
//   master: drives requests and wr_stall, observes ready/write port/status
//   slave : the writeback block
interface reg_file_writeback_if
    import reg_file_pkg::*;
;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [REG_DATA_W-1:0] alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [REG_DATA_W-1:0] mem_data;
    logic                  wr_stall;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [REG_DATA_W-1:0] wr_data;
    logic [NUM_REGS-1:0]   pending;
    logic [WB_CNT_W-1:0]   fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output wr_stall,
        input  alu_ready, mem_ready,
        input  wr_en, wr_reg, wr_data, pending, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  wr_stall,
        output alu_ready, mem_ready,
        output wr_en, wr_reg, wr_data, pending, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order writeback buffer with wrapping pointers. Per-slot valid flags and
// contents are exposed so the parent can compute outstanding destinations.
// Ports: clk, rst_n, push/push_data, pop/pop_data, full, empty, count,
//        slot_valid/slots (occupancy view).
module wb_fifo
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_entry_t                    push_data,
    input  logic                         pop,
    output wb_entry_t                    pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0]             slot_valid,
    output wb_entry_t                    slots [DEPTH]
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    // Overflow/underflow requests are ignored
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        pop_data = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                mem_q[wr_ptr_q]   <= push_data;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count      = count_q;
    assign slot_valid = valid_q;
    assign slots      = mem_q;

endmodule

// File: rtl/reg_file_writeback.sv
// Register-file writeback: arbitrates ALU and load-unit results into a small
// buffer and drains it through a registered write port when not stalled.
// Ports: clk, rst_n (async, active-low), bus (slave side of the writeback
//        interface: request channels, wr_stall, write port, pending, count).
module reg_file_writeback
    import reg_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    reg_file_writeback_if.slave   bus
);

    logic [STARVE_W-1:0]   starve_q;
    logic                  wr_en_q;
    logic [REG_ADDR_W-1:0] wr_reg_q;
    logic [REG_DATA_W-1:0] wr_data_q;

    logic                  grant_alu;
    logic                  grant_mem;
    logic                  alu_ready_c;
    logic                  mem_ready_c;
    logic                  alu_acc;
    logic                  mem_acc;
    logic                  push;
    logic                  pop;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WB_CNT_W-1:0]   fifo_count;
    logic [WB_FIFO_DEPTH-1:0] slot_valid;
    wb_entry_t             slots [WB_FIFO_DEPTH];
    logic [NUM_REGS-1:0]   pending_c;

    // Loads win unless the ALU has waited long enough; no accept while full
    // and ready is forced low while reset is asserted.
    always_comb begin
        grant_alu   = bus.alu_valid &&
                      ((starve_q == STARVE_W'(STARVE_LIMIT)) || !bus.mem_valid);
        grant_mem   = bus.mem_valid && !grant_alu;
        alu_ready_c = rst_n && grant_alu && !fifo_full;
        mem_ready_c = rst_n && grant_mem && !fifo_full;
        alu_acc     = bus.alu_valid && alu_ready_c;
        mem_acc     = bus.mem_valid && mem_ready_c;
        push_entry.rd   = mem_acc ? bus.mem_rd   : bus.alu_rd;
        push_entry.data = mem_acc ? bus.mem_data : bus.alu_data;
        // Writes to x0 complete the handshake but are dropped
        push        = (alu_acc || mem_acc) && (push_entry.rd != '0);
        pop         = !bus.wr_stall && !fifo_empty;
    end

    wb_fifo #(
        .DEPTH (WB_FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .pop_data   (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .slot_valid (slot_valid),
        .slots      (slots)
    );

    // ALU starvation counter, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!bus.alu_valid || alu_acc) begin
            starve_q <= '0;
        end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    // Registered write port: loads the head on a pop, otherwise idles to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else if (pop) begin
            wr_en_q   <= 1'b1;
            wr_reg_q  <= head.rd;
            wr_data_q <= head.data;
        end else begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end
    end

    // Destinations still buffered or being written this cycle
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < int'(WB_FIFO_DEPTH); i++) begin
            if (slot_valid[i]) begin
                pending_c[slots[i].rd] = 1'b1;
            end
        end
        if (wr_en_q) begin
            pending_c[wr_reg_q] = 1'b1;
        end
        pending_c[0] = 1'b0;
    end

    assign bus.alu_ready  = alu_ready_c;
    assign bus.mem_ready  = mem_ready_c;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_reg     = wr_reg_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.pending    = pending_c;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_reg_file_writeback.sv
// Directed vector bench for reg_file_writeback.
module tb_reg_file_writeback;
    import reg_file_pkg::*;

    logic clk;
    logic rst_n;

    reg_file_writeback_if bus ();

    reg_file_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        st;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [31:0] e_pend;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(string tag, logic rst,
                                logic av, logic [4:0] ard, logic [31:0] ad,
                                logic mv, logic [4:0] mrd, logic [31:0] md,
                                logic st,
                                logic ear, logic emr, logic ewe, logic [4:0] ewr,
                                logic [31:0] ewd, logic [31:0] epend, logic [1:0] ecnt);
        vec_t v;
        v.tag = tag; v.rst = rst;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md; v.st = st;
        v.e_ar = ear; v.e_mr = emr; v.e_we = ewe; v.e_wreg = ewr;
        v.e_wdata = ewd; v.e_pend = epend; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic av, logic [4:0] ard, logic [31:0] ad,
                         logic mv, logic [4:0] mrd, logic [31:0] md, logic st);
        rst_n         = rst;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.wr_stall  = st;
    endtask

    task automatic check_all(string tag, logic ear, logic emr, logic ewe, logic [4:0] ewr,
                             logic [31:0] ewd, logic [31:0] epend, logic [1:0] ecnt);
        chk({tag, ".alu_ready"},  32'(bus.alu_ready),  32'(ear));
        chk({tag, ".mem_ready"},  32'(bus.mem_ready),  32'(emr));
        chk({tag, ".wr_en"},      32'(bus.wr_en),      32'(ewe));
        chk({tag, ".wr_reg"},     32'(bus.wr_reg),     32'(ewr));
        chk({tag, ".wr_data"},    bus.wr_data,         ewd);
        chk({tag, ".pending"},    bus.pending,         epend);
        chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(ecnt));
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        //                 tag   rst av ard ad          mv mrd md            st  ar mr we wreg wdata         pend         cnt
        vecs.push_back(mk("rst",  0, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("idle", 1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        // single load, latency and pending window
        vecs.push_back(mk("a0",   1, 0, 0, 32'h0,       1, 5, 32'hDEADBEEF,  0,  0, 1, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("a1",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h20,      1));
        vecs.push_back(mk("a2",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 5, 32'hDEADBEEF, 32'h20,      0));
        vecs.push_back(mk("a3",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        // write to x0 is accepted and dropped
        vecs.push_back(mk("c0",   1, 1, 0, 32'h1234,    0, 0, 32'h0,         0,  1, 0, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("c1",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("c2",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        // contention under stall, starvation override after release
        vecs.push_back(mk("b0",   1, 1, 1, 32'hA1,      1, 2, 32'hB2,        1,  0, 1, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("b1",   1, 1, 1, 32'hA1,      1, 3, 32'hB3,        1,  0, 1, 0, 0, 32'h0,        32'h4,       1));
        vecs.push_back(mk("b2",   1, 1, 1, 32'hA1,      1, 4, 32'hB4,        1,  0, 0, 0, 0, 32'h0,        32'hC,       2));
        vecs.push_back(mk("b3",   1, 1, 1, 32'hA1,      1, 4, 32'hB4,        1,  0, 0, 0, 0, 32'h0,        32'hC,       2));
        vecs.push_back(mk("b4",   1, 1, 1, 32'hA1,      1, 4, 32'hB4,        0,  0, 0, 0, 0, 32'h0,        32'hC,       2));
        vecs.push_back(mk("b5",   1, 1, 1, 32'hA1,      1, 4, 32'hB4,        0,  1, 0, 1, 2, 32'hB2,       32'hC,       1));
        vecs.push_back(mk("b6",   1, 0, 0, 32'h0,       1, 4, 32'hB4,        0,  0, 1, 1, 3, 32'hB3,       32'hA,       1));
        vecs.push_back(mk("b7",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 1, 32'hA1,       32'h12,      1));
        vecs.push_back(mk("b8",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 4, 32'hB4,       32'h10,      0));
        vecs.push_back(mk("b9",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        // full with stall released: pop first, accept next cycle
        vecs.push_back(mk("d0",   1, 0, 0, 32'h0,       1, 8, 32'h80,        1,  0, 1, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("d1",   1, 0, 0, 32'h0,       1, 9, 32'h90,        1,  0, 1, 0, 0, 32'h0,        32'h100,     1));
        vecs.push_back(mk("d2",   1, 0, 0, 32'h0,       1, 10, 32'hA0,       0,  0, 0, 0, 0, 32'h0,        32'h300,     2));
        vecs.push_back(mk("d3",   1, 0, 0, 32'h0,       1, 10, 32'hA0,       0,  0, 1, 1, 8, 32'h80,       32'h300,     1));
        vecs.push_back(mk("d4",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 9, 32'h90,       32'h600,     1));
        vecs.push_back(mk("d5",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 10, 32'hA0,      32'h400,     0));
        vecs.push_back(mk("d6",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        // duplicate destination, acceptance order preserved across a stall
        vecs.push_back(mk("e0",   1, 1, 7, 32'h1,       0, 0, 32'h0,         0,  1, 0, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("e1",   1, 1, 7, 32'h2,       0, 0, 32'h0,         1,  1, 0, 0, 0, 32'h0,        32'h80,      1));
        vecs.push_back(mk("e2",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h80,      2));
        vecs.push_back(mk("e3",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 7, 32'h1,        32'h80,      1));
        vecs.push_back(mk("e4",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 7, 32'h2,        32'h80,      0));
        vecs.push_back(mk("e5",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        // reset with a full buffer, then first accept right after release
        vecs.push_back(mk("r0",   1, 0, 0, 32'h0,       1, 11, 32'h11,       1,  0, 1, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("r1",   1, 0, 0, 32'h0,       1, 12, 32'h12,       1,  0, 1, 0, 0, 32'h0,        32'h800,     1));
        vecs.push_back(mk("r2",   1, 1, 14, 32'h14,     1, 13, 32'h13,       1,  0, 0, 0, 0, 32'h0,        32'h1800,    2));
        vecs.push_back(mk("r3",   0, 1, 14, 32'h14,     1, 13, 32'h13,       0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("r4",   0, 1, 14, 32'h14,     1, 13, 32'h13,       0,  0, 0, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("r5",   1, 0, 0, 32'h0,       1, 5, 32'h55,        0,  0, 1, 0, 0, 32'h0,        32'h0,       0));
        vecs.push_back(mk("r6",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h20,      1));
        vecs.push_back(mk("r7",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 1, 5, 32'h55,       32'h20,      0));
        vecs.push_back(mk("r8",   1, 0, 0, 32'h0,       0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0,        32'h0,       0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].ad,
                  vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].st);
            #1;
            check_all(vecs[i].tag, vecs[i].e_ar, vecs[i].e_mr, vecs[i].e_we, vecs[i].e_wreg,
                      vecs[i].e_wdata, vecs[i].e_pend, vecs[i].e_cnt);
        end

        // Asynchronous reset between edges while a write is on the port
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h2020, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd21, 32'h2121, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        check_all("h_pre", 1'b0, 1'b0, 1'b1, 5'd20, 32'h2020, 32'h0030_0000, 2'd1);
        drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h22, 1'b0);
        #1;
        check_all("h_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("h_post%0d.wr_en", k), 32'(bus.wr_en), 32'h0);
            chk($sformatf("h_post%0d.fifo_count", k), 32'(bus.fifo_count), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
